alarm_snooze_ctrl: RTL

//  Downstream of the alarm clock core, in the clk_1s domain. Consumes its Alarm level and

---
 rtl/alarm_pkg.sv | 20 ++
 rtl/alarm_snooze_ctrl_btn_rise_det.sv | 21 ++
 rtl/alarm_snooze_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm snooze/dismiss controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } snz_state_t;

    localparam int SNOOZE_SEC_D   = 300;
    localparam int MAX_SNOOZE_D   = 3;
    localparam int RING_TIMEOUT_D = 120;
    localparam int ESC_SEC_D      = 10;

    // Width needed to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/alarm_snooze_ctrl_btn_rise_det.sv
// Rising-edge detector for an already-synchronised level: rise = d now and not d last edge.
module btn_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm buzzer controller: ring / snooze / dismiss / auto-timeout with stop_al handshake.
// Optional pulsed-beep start of ringing is enabled by defining SNOOZE_ESCALATE_EN.
module alarm_snooze_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC   = SNOOZE_SEC_D,
    parameter int MAX_SNOOZE   = MAX_SNOOZE_D,
    parameter int RING_TIMEOUT = RING_TIMEOUT_D,
    parameter int ESC_SEC      = ESC_SEC_D
) (
    input  logic                                clk_1s,
    input  logic                                reset,
    input  logic                                alarm_in,
    input  logic                                snooze_btn,
    input  logic                                dismiss_btn,
    output logic                                buzzer,
    output logic                                stop_al,
    output logic                                snoozing,
    output logic [$clog2(SNOOZE_SEC+1)-1:0]     snooze_left,
    output logic [cnt_width(MAX_SNOOZE)-1:0]    snoozes_used,
    output logic                                timed_out
);

    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam int NW = cnt_width(MAX_SNOOZE);
    localparam int RW = $clog2(RING_TIMEOUT);

    localparam logic [SW-1:0] SNOOZE_FULL = SW'(SNOOZE_SEC);
    localparam logic [SW-1:0] SNOOZE_ONE  = SW'(1);
    localparam logic [NW-1:0] SNZ_LIMIT   = NW'(MAX_SNOOZE);
    localparam logic [RW-1:0] RING_LAST   = RW'(RING_TIMEOUT - 1);

`ifdef SNOOZE_ESCALATE_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif

    // Bit order: 0 = alarm_in, 1 = snooze_btn, 2 = dismiss_btn
    logic [2:0] lvl;
    logic [2:0] rise;
    logic       alarm_rise;
    logic       snooze_rise;
    logic       dismiss_rise;

    assign lvl = {dismiss_btn, snooze_btn, alarm_in};

    for (genvar gi = 0; gi < 3; gi++) begin : g_rise
        btn_rise_det u_rise (
            .clk   (clk_1s),
            .reset (reset),
            .d     (lvl[gi]),
            .rise  (rise[gi])
        );
    end

    assign alarm_rise   = rise[0];
    assign snooze_rise  = rise[1];
    assign dismiss_rise = rise[2];

    snz_state_t      state_q, state_d;
    logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
    logic [SW-1:0]   snooze_left_q, snooze_left_d;
    logic [NW-1:0]   snoozes_used_q, snoozes_used_d;
    logic            timed_out_q, timed_out_d;
    logic            stop_al_q, stop_al_d;
    logic            buzzer_q, buzzer_d;
    logic            snoozing_q, snoozing_d;
    logic            stop_ev;
    logic            beep_phase;

    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snooze_left_d  = snooze_left_q;
        snoozes_used_d = snoozes_used_q;
        timed_out_d    = timed_out_q;
        stop_ev        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (alarm_rise) begin
                    state_d        = S_RING;
                    ring_cnt_d     = '0;
                    snoozes_used_d = '0;
                    timed_out_d    = 1'b0;
                end
            end

            S_RING: begin
                if (ring_cnt_q != RING_LAST) begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                end
                if (dismiss_rise) begin
                    state_d = S_IDLE;
                    stop_ev = 1'b1;
                end else if (snooze_rise && (snoozes_used_q < SNZ_LIMIT)) begin
                    state_d        = S_SNOOZE;
                    stop_ev        = 1'b1;
                    snooze_left_d  = SNOOZE_FULL;
                    snoozes_used_d = snoozes_used_q + 1'b1;
                end else if (ring_cnt_q == RING_LAST) begin
                    state_d     = S_IDLE;
                    stop_ev     = 1'b1;
                    timed_out_d = 1'b1;
                end
            end

            S_SNOOZE: begin
                if (snooze_left_q != '0) begin
                    snooze_left_d = snooze_left_q - 1'b1;
                end
                if (dismiss_rise) begin
                    state_d       = S_IDLE;
                    stop_ev       = 1'b1;
                    snooze_left_d = '0;
                end else if (snooze_left_q == SNOOZE_ONE) begin
                    // Internal re-ring: the core's Alarm was already cleared at snooze time.
                    state_d       = S_RING;
                    snooze_left_d = '0;
                    ring_cnt_d    = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A transition right after a pulse (snooze then immediate dismiss) would stretch
    // stop_al to two cycles; the core latch is already clear then, so it is dropped.
    assign stop_al_d = stop_ev & ~stop_al_q;

    if (ESC_EN && (ESC_SEC > 0)) begin : g_esc
        assign beep_phase = (32'(ring_cnt_d) >= 32'($unsigned(ESC_SEC))) | ~ring_cnt_d[0];
    end else begin : g_cont
        assign beep_phase = 1'b1;
    end

    assign buzzer_d   = (state_d == S_RING) & beep_phase;
    assign snoozing_d = (state_d == S_SNOOZE);

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ring_cnt_q     <= '0;
            snooze_left_q  <= '0;
            snoozes_used_q <= '0;
            timed_out_q    <= 1'b0;
            stop_al_q      <= 1'b0;
            buzzer_q       <= 1'b0;
            snoozing_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ring_cnt_q     <= ring_cnt_d;
            snooze_left_q  <= snooze_left_d;
            snoozes_used_q <= snoozes_used_d;
            timed_out_q    <= timed_out_d;
            stop_al_q      <= stop_al_d;
            buzzer_q       <= buzzer_d;
            snoozing_q     <= snoozing_d;
        end
    end

    assign buzzer       = buzzer_q;
    assign stop_al      = stop_al_q;
    assign snoozing     = snoozing_q;
    assign snooze_left  = snooze_left_q;
    assign snoozes_used = snoozes_used_q;
    assign timed_out    = timed_out_q;

endmodule
